// File: rtl/vga_sync.sv
// 640x480@60 VGA raster timing generator: pixel/line counters, per-axis
// video enables and sync pulses, all registered and aligned to the same (x,y).
module vga_sync #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       h_video_en,
   output logic       v_video_en,
   output logic       hsync,
   output logic       vsync,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Comparison bounds are 11 bits so a sync window ending at 1024 still fits.
   localparam logic [10:0] H_ACT_L  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEG_L = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END_L = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  H_LAST_L = 10'(H_TOTAL - 1);
   localparam logic [10:0] V_ACT_L  = 11'(V_ACTIVE);
   localparam logic [10:0] VS_BEG_L = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END_L = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0]  V_LAST_L = 10'(V_TOTAL - 1);

   localparam logic SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
   localparam logic SYNC_OFF = (SYNC_POL != 0) ? 1'b0 : 1'b1;

   if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_total_check
      $error("vga_sync: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   // ST_LOAD is the single edge after reset that presents (0,0) without counting.
   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t     state_r;
   state_t     state_nxt_s;
   logic [9:0] h_r;
   logic [9:0] v_r;
   logic [9:0] h_nxt_s;
   logic [9:0] v_nxt_s;
   logic       h_en_r;
   logic       v_en_r;
   logic       hsync_r;
   logic       vsync_r;
   logic       h_en_nxt_s;
   logic       v_en_nxt_s;
   logic       hsync_nxt_s;
   logic       vsync_nxt_s;

   // Next-state and next counter position.
   always_comb begin
      state_nxt_s = state_r;
      h_nxt_s     = h_r;
      v_nxt_s     = v_r;
      case (state_r)
         ST_LOAD: begin
            state_nxt_s = ST_RUN;
            h_nxt_s     = 10'd0;
            v_nxt_s     = 10'd0;
         end
         ST_RUN: begin
            if (h_r == H_LAST_L) begin
               h_nxt_s = 10'd0;
               if (v_r == V_LAST_L) begin
                  v_nxt_s = 10'd0;
               end else begin
                  v_nxt_s = v_r + 10'd1;
               end
            end else begin
               h_nxt_s = h_r + 10'd1;
               v_nxt_s = v_r;
            end
         end
         default: begin
            state_nxt_s = ST_LOAD;
            h_nxt_s     = 10'd0;
            v_nxt_s     = 10'd0;
         end
      endcase
   end

   // Decode enables and syncs from the next position so outputs stay aligned.
   always_comb begin
      h_en_nxt_s  = 1'b0;
      v_en_nxt_s  = 1'b0;
      hsync_nxt_s = SYNC_OFF;
      vsync_nxt_s = SYNC_OFF;
      if ({1'b0, h_nxt_s} < H_ACT_L) begin
         h_en_nxt_s = 1'b1;
      end else begin
         h_en_nxt_s = 1'b0;
      end
      if ({1'b0, v_nxt_s} < V_ACT_L) begin
         v_en_nxt_s = 1'b1;
      end else begin
         v_en_nxt_s = 1'b0;
      end
      if (({1'b0, h_nxt_s} >= HS_BEG_L) && ({1'b0, h_nxt_s} < HS_END_L)) begin
         hsync_nxt_s = SYNC_ON;
      end else begin
         hsync_nxt_s = SYNC_OFF;
      end
      if (({1'b0, v_nxt_s} >= VS_BEG_L) && ({1'b0, v_nxt_s} < VS_END_L)) begin
         vsync_nxt_s = SYNC_ON;
      end else begin
         vsync_nxt_s = SYNC_OFF;
      end
   end

   // State, counters and output flops; reset parks everything in blanking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_LOAD;
         h_r     <= 10'd0;
         v_r     <= 10'd0;
         h_en_r  <= 1'b0;
         v_en_r  <= 1'b0;
         hsync_r <= SYNC_OFF;
         vsync_r <= SYNC_OFF;
      end else begin
         state_r <= state_nxt_s;
         h_r     <= h_nxt_s;
         v_r     <= v_nxt_s;
         h_en_r  <= h_en_nxt_s;
         v_en_r  <= v_en_nxt_s;
         hsync_r <= hsync_nxt_s;
         vsync_r <= vsync_nxt_s;
      end
   end

   assign pixel_x    = h_r;
   assign pixel_y    = v_r;
   assign h_video_en = h_en_r;
   assign v_video_en = v_en_r;
   assign hsync      = hsync_r;
   assign vsync      = vsync_r;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync using a shrunken raster (32x15 totals) so
// several whole frames fit in a short run.
module tb_vga_sync;

   logic       clk;
   logic       rst_n;
   logic       h_video_en;
   logic       v_video_en;
   logic       hsync;
   logic       vsync;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;

   int checks;
   int failures;

   // Line: 16 active, fp 4, sync 6 (x 20..25), bp 6 -> 32.
   // Frame: 8 active, fp 2, sync 2 (y 10..11), bp 3 -> 15 lines, 480 clocks.
   vga_sync #(
      .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
      .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
      .SYNC_POL(0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .h_video_en (h_video_en),
      .v_video_en (v_video_en),
      .hsync      (hsync),
      .vsync      (vsync),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y)
   );

   initial begin
      clk = 1'b1;
      forever #20 clk = ~clk;
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_x"},    int'(pixel_x),    0);
      check({tag, "_y"},    int'(pixel_y),    0);
      check({tag, "_hs"},   int'(hsync),      1);
      check({tag, "_vs"},   int'(vsync),      1);
      check({tag, "_hen"},  int'(h_video_en), 0);
      check({tag, "_ven"},  int'(v_video_en), 0);
   endtask

   initial begin
      int ex, ey;
      int hs_run, hen_run, vs_run;
      int last_hs_fall, last_vs_fall;
      logic p_hs, p_vs, p_hen, p_ven;
      bit found;

      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;

      #50;
      check_reset_vals("rst_a");
      #40;
      check_reset_vals("rst_b");
      #10;
      rst_n = 1'b1;                        // t = 100 ns, next edge at 120 ns

      @(posedge clk);
      #20;
      check("load_x",   int'(pixel_x),    0);
      check("load_y",   int'(pixel_y),    0);
      check("load_hen", int'(h_video_en), 1);
      check("load_ven", int'(v_video_en), 1);
      check("load_hs",  int'(hsync),      1);
      check("load_vs",  int'(vsync),      1);

      ex = 0; ey = 0;
      p_hs = hsync; p_vs = vsync; p_hen = h_video_en; p_ven = v_video_en;
      hs_run = 1; hen_run = 1; vs_run = 1;
      last_hs_fall = -1; last_vs_fall = -1;

      for (int cyc = 1; cyc <= 1500; cyc++) begin
         @(posedge clk);
         #20;
         ex++;
         if (ex == 32) begin
            ex = 0;
            ey++;
            if (ey == 15) ey = 0;
         end
         check("x",   int'(pixel_x),    ex);
         check("y",   int'(pixel_y),    ey);
         check("hen", int'(h_video_en), (ex < 16) ? 1 : 0);
         check("ven", int'(v_video_en), (ey < 8) ? 1 : 0);
         check("hs",  int'(hsync),      (ex >= 20 && ex <= 25) ? 0 : 1);
         check("vs",  int'(vsync),      (ey >= 10 && ey <= 11) ? 0 : 1);

         if (h_video_en !== p_hen) begin
            check(p_hen ? "hen_high_len" : "hen_low_len", hen_run, 16);
            hen_run = 1;
         end else hen_run++;

         if (hsync !== p_hs) begin
            if (!hsync) begin
               check("hs_fall_x", int'(pixel_x), 20);
               if (last_hs_fall >= 0) check("hs_period", cyc - last_hs_fall, 32);
               last_hs_fall = cyc;
            end else begin
               check("hs_low_len", hs_run, 6);
            end
            hs_run = 1;
         end else hs_run++;

         if (vsync !== p_vs) begin
            if (!vsync) begin
               check("vs_fall_x", int'(pixel_x), 0);
               check("vs_fall_y", int'(pixel_y), 10);
               if (last_vs_fall >= 0) check("vs_period", cyc - last_vs_fall, 480);
               last_vs_fall = cyc;
            end else begin
               check("vs_low_len", vs_run, 64);
            end
            vs_run = 1;
         end else vs_run++;

         if (p_ven && !v_video_en) begin
            check("ven_fall_y", int'(pixel_y), 8);
            check("ven_fall_x", int'(pixel_x), 0);
         end

         p_hs = hsync; p_vs = vsync; p_hen = h_video_en; p_ven = v_video_en;
      end

      // Mid-frame asynchronous reset at (10,5).
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(posedge clk);
         #20;
         if (pixel_x == 10'd10 && pixel_y == 10'd5) found = 1'b1;
      end
      check("mid_reach", int'(found), 1);
      #5;
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid_rst");
      @(negedge clk);
      check_reset_vals("mid_hold");
      rst_n = 1'b1;
      @(posedge clk);
      #20;
      check("restart_x",   int'(pixel_x),    0);
      check("restart_y",   int'(pixel_y),    0);
      check("restart_hen", int'(h_video_en), 1);
      check("restart_ven", int'(v_video_en), 1);
      @(posedge clk);
      #20;
      check("restart2_x", int'(pixel_x), 1);
      check("restart2_y", int'(pixel_y), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_sync.md
# vga_sync

VGA timing generator for the Miz702 VGA output path. It produces the 640x480@60 Hz raster from a 25 MHz pixel clock (40 ns period). Outputs are horizontal and vertical sync, per-axis active-video enables, and the current pixel coordinates. Downstream pixel generators use `h_video_en & v_video_en` together with `pixel_x`/`pixel_y` to drive RGB.

## Interface
Parameters:
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch, in clocks.
- `H_SYNC`, default 96: hsync pulse width, in clocks.
- `H_BP`, default 48: horizontal back porch, in clocks. Line total is 800.
- `V_ACTIVE`, default 480: visible lines.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync pulse width, in lines.
- `V_BP`, default 33: vertical back porch, in lines. Frame total is 525.
- `SYNC_POL`, default 0: sync asserted level (0 = active-low).

Ports:
- `clk`, input, 1: 25 MHz pixel clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `h_video_en`, output, 1: horizontal position is inside the visible region.
- `v_video_en`, output, 1: vertical position is inside the visible region.
- `hsync`, output, 1: horizontal sync.
- `vsync`, output, 1: vertical sync.
- `pixel_x`, output, 10: current horizontal count, 0..H_TOTAL-1.
- `pixel_y`, output, 10: current vertical count, 0..V_TOTAL-1.

Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both totals must be ≤ 1024; a violation is an elaboration error.

## Operation
- Horizontal counter h counts 0..H_TOTAL-1 and increments every clock. At H_TOTAL-1 it wraps to 0.
- Vertical counter v increments only on the edge where h wraps. At V_TOTAL-1, on that same h wrap, it wraps to 0.
- `pixel_x` = h and `pixel_y` = v. These are raw counts and are not zeroed during blanking.
- `h_video_en` = (h < H_ACTIVE).
- `v_video_en` = (v < V_ACTIVE).
- `hsync` is asserted (= SYNC_POL) for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], which is 656..751 at defaults. Otherwise it equals ~SYNC_POL.
- `vsync` is asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], which is lines 490..491 at defaults. It spans whole lines and changes only on h wrap.
- All outputs are registered flops. Each is computed from the next counter value, so every output describes the same (h,v) position in the same cycle. There is no skew between `pixel_x` and the enables or syncs.

## Timing
- Reset values while `rst_n`=0, held asynchronously:
  - `pixel_x`=0, `pixel_y`=0
  - `hsync`=1, `vsync`=1 (deasserted at SYNC_POL=0)
  - `h_video_en`=0, `v_video_en`=0
- First rising edge after `rst_n` rises: outputs present position (0,0), with `h_video_en`=1, `v_video_en`=1, `hsync`=1 and `vsync`=1. Each following edge advances one pixel. An internal "started" flag distinguishes this load edge from normal counting.
- Line period is 800 clocks (32 µs). Frame period is 420000 clocks (16.8 ms).
- `hsync` falls on the edge where `pixel_x` becomes 656. It rises on the edge where `pixel_x` becomes 752, giving a low width of 96 clocks.
- `vsync` falls on the edge where (x,y) becomes (0,490). It rises at (0,492), giving a low width of 1600 clocks.
- End-of-frame wrap: in one edge, (799,524) goes to (0,0), and both enables go to 1.
- Reset asserted mid-frame: all outputs return to their reset values immediately, without waiting for a clock edge. Restart behaves exactly as after power-up reset.

## Test plan
- Reset release at 100 ns, 40 ns clock:
  - During reset, all outputs hold their reset values.
  - At the first edge after release, (`pixel_x`,`pixel_y`)=(0,0) and `h_video_en`=`v_video_en`=1.
- Horizontal sweep: `h_video_en` is 1 for exactly 640 consecutive clocks and 0 for 160. `hsync` is low for exactly 96 clocks, beginning at `pixel_x`=656.
- Line wrap:
  - After `pixel_x`=799, the next cycle shows `pixel_x`=0 and `pixel_y`+1.
  - `pixel_y` is otherwise stable across the line.
- Vertical:
  - `v_video_en` falls when `pixel_y`=480.
  - `vsync` is low only while `pixel_y` is 490 or 491, i.e. 1600 clocks.
  - After `pixel_y`=524 and `pixel_x`=799, the next cycle is (0,0).
- Periodicity: consecutive `vsync` falling edges are 420000 clocks apart. Consecutive `hsync` falling edges are 800 clocks apart.
- Mid-frame reset: assert `rst_n`=0 asynchronously at an arbitrary point, e.g. (300,200).
  - Outputs return to their reset values immediately, without waiting for a clock edge.
  - After release, counting restarts at (0,0).
